// File: rtl/borrow_divider_pkg.sv
// Shared types and constants for the restoring divider.
// Holds the FSM state encoding and the default operand width.
package borrow_divider_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/borrow_lookahead_sub.sv
// Combinational a - b with every borrow from a flat two-level
// generate/propagate lookahead, so no borrow ripples bit to bit.
module borrow_lookahead_sub
   import borrow_divider_pkg::*;
#(
   parameter int N = DEF_WIDTH + 1
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_diff,
   output logic         o_bout
);

   logic [N-1:0] w_g;
   logic [N-1:0] w_p;
   logic [N:0]   w_bor;

   assign w_g      = ~i_a & i_b;
   assign w_p      = ~(i_a ^ i_b);
   assign w_bor[0] = 1'b0;

   // Borrow into bit i+1: any g[j] whose path p[i:j+1] is all ones.
   for (genvar i = 0; i < N; i++) begin : g_bor
      logic [i:0] w_term;
      for (genvar j = 0; j <= i; j++) begin : g_term
         if (j == i) begin : g_last
            assign w_term[j] = w_g[j];
         end else begin : g_path
            assign w_term[j] = w_g[j] & (&w_p[i:j+1]);
         end
      end
      assign w_bor[i+1] = |w_term;
   end

   assign o_diff = ~w_p ^ w_bor[N-1:0];
   assign o_bout = w_bor[N];

endmodule

// File: rtl/borrow_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle,
// using a borrow-lookahead subtractor for each trial subtraction.
module borrow_divider
   import borrow_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   state_t r_state;
   state_t w_next;

   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic             r_dbz;

   logic             w_busy;
   logic             w_done;
   logic             w_zero;
   logic [WIDTH:0]   w_a;
   logic [WIDTH:0]   w_b;
   logic [WIDTH:0]   w_diff;
   logic             w_bout;
   logic             w_unused_msb;

   assign w_zero       = (divisor == '0);
   assign w_a          = {r_rem, r_dvd[WIDTH-1]};
   assign w_b          = {1'b0, r_dvs};
   assign w_unused_msb = w_diff[WIDTH];

   borrow_lookahead_sub #(
      .N (WIDTH + 1)
   ) u_sub (
      .i_a    (w_a),
      .i_b    (w_b),
      .o_diff (w_diff),
      .o_bout (w_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_next = w_zero ? DONE : RUN;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            if (r_step[WIDTH-1]) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // r_step is a one-hot step marker; its top bit flags the last step.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dvd  <= '0;
         r_dvs  <= '0;
         r_step <= '0;
         r_quo  <= '0;
         r_rem  <= '0;
         r_dbz  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_dvd  <= dividend;
                  r_dvs  <= divisor;
                  r_step <= {{(WIDTH-1){1'b0}}, 1'b1};
                  r_dbz  <= w_zero;
                  r_quo  <= w_zero ? '1 : '0;
                  r_rem  <= w_zero ? dividend : '0;
               end
            end
            RUN: begin
               r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
               r_step <= {r_step[WIDTH-2:0], 1'b0};
               r_quo  <= {r_quo[WIDTH-2:0], ~w_bout};
               r_rem  <= w_bout ? w_a[WIDTH-1:0] : w_diff[WIDTH-1:0];
            end
            default: begin
            end
         endcase
      end
   end

   assign busy        = w_busy;
   assign done        = w_done;
   assign quotient    = r_quo;
   assign remainder   = r_rem;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_borrow_divider.sv
// Scoreboard bench for borrow_divider: directed operand pairs,
// expected results queued at issue and checked when done pulses.
module tb_borrow_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      int         acc;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   borrow_divider #(
      .WIDTH (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", int'(quotient), int'(e.q));
            chk("remainder", int'(remainder), int'(e.r));
            chk("div_by_zero", int'(div_by_zero), int'(e.z));
            chk("latency", cyc - e.acc + 1, e.lat);
            chk("busy_at_done", int'(busy), 1);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] q, input logic [7:0] r,
                        input bit push, output int acc);
      exp_t e;
      wait_idle();
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      acc      = cyc;
      start    = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
      if (push) begin
         e.q   = q;
         e.r   = r;
         e.z   = (b == 8'd0);
         e.acc = acc;
         e.lat = (b == 8'd0) ? 1 : 9;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_q"}, int'(quotient), 0);
      chk({tag, "_r"}, int'(remainder), 0);
      chk({tag, "_dbz"}, int'(div_by_zero), 0);
   endtask

   initial begin
      int acc;
      int n;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      issue(8'd100, 8'd7, 8'd14, 8'd2, 1, acc);
      issue(8'd255, 8'd1, 8'd255, 8'd0, 1, acc);
      issue(8'd5, 8'd9, 8'd0, 8'd5, 1, acc);
      issue(8'd255, 8'd255, 8'd1, 8'd0, 1, acc);
      issue(8'd37, 8'd0, 8'hFF, 8'd37, 1, acc);
      issue(8'd0, 8'd0, 8'hFF, 8'd0, 1, acc);
      issue(8'd200, 8'd3, 8'd66, 8'd2, 1, acc);
      issue(8'd128, 8'd16, 8'd8, 8'd0, 1, acc);
      issue(8'd0, 8'd5, 8'd0, 8'd0, 1, acc);
      issue(8'd254, 8'd127, 8'd2, 8'd0, 1, acc);
      issue(8'd250, 8'd251, 8'd0, 8'd250, 1, acc);

      issue(8'd100, 8'd7, 8'd14, 8'd2, 1, acc);
      repeat (2) @(negedge clk);
      start    = 1'b1;
      dividend = 8'd200;
      divisor  = 8'd3;
      @(negedge clk);
      start    = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      chk("hold_q", int'(quotient), 14);
      chk("hold_r", int'(remainder), 2);

      issue(8'd100, 8'd7, 8'd0, 8'd0, 0, acc);
      repeat (3) @(negedge clk);
      chk("run_busy", int'(busy), 1);
      chk("run_done", int'(done), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk_zero("abort");
      repeat (12) @(negedge clk);
      chk("abort_idle", int'(busy), 0);
      issue(8'd50, 8'd6, 8'd8, 8'd2, 1, acc);

      issue(8'd199, 8'd10, 8'd19, 8'd9, 1, acc);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", int'(done), 1);
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd6;
      @(posedge clk);
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e.q   = 8'd8;
         e.r   = 8'd2;
         e.z   = 1'b0;
         e.acc = cyc;
         e.lat = 9;
         sb.push_back(e);
      end
      start    = 1'b0;
      dividend = 8'd1;
      divisor  = 8'd1;
      @(negedge clk);
      wait_idle();

      repeat (4) @(negedge clk);
      chk("pending_at_end", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
